// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// The optional ENTER debouncer is enabled with the CALC_DEBOUNCE_EN macro.
package calc_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_sequencer_key_pulse.sv
// Turns the raw asynchronous ENTER level into a single-cycle pulse.
// Define CALC_DEBOUNCE_EN to insert a stable-level debouncer after the synchronizer.
module key_pulse #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       level;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      prev_q <= level;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt_q;
  logic          db_q;

  // The debounced level only follows a new level held for DEBOUNCE_CYCLES edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (sync_q[1] == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= sync_q[1];
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign level = db_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign level = sync_q[1];
`endif

  assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM sequencing the shared external adder/subtractor of the keypad calculator.
// Build with CALC_DEBOUNCE_EN defined to debounce the ENTER key.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N               = N_DEFAULT,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENTER,
  input  logic         ABORT,
  input  logic         OP,
  input  logic         ISVALID,
  input  logic [N-1:0] BinTC,
  input  logic [N-1:0] SUM,
  input  logic         COUT,
  output logic [N-1:0] OPA,
  output logic [N-1:0] OPB,
  output logic         ADD_SUB,
  output logic [N-1:0] RESULT,
  output logic         COUT_Q,
  output logic         OVF,
  output logic         ERR,
  output logic         DONE,
  output logic [1:0]   STATE,
  output logic [N-1:0] DISP
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e         state_q;
  logic [N-1:0]   opa_q, opb_q, result_q, disp_q;
  logic           add_sub_q, cout_q, ovf_q, err_q, done_q;
  logic [CW-1:0]  cnt_q;

  logic           ent;
  logic [N-1:0]   bx;
  logic           ovf_d;
  logic [N-1:0]   disp_d;

  key_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_pulse (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw_i  (ENTER),
    .pulse_o(ent)
  );

  // Signed overflow: both addends share a sign and the sum's sign differs.
  assign bx    = (add_sub_q == OP_SUB) ? ~opb_q : opb_q;
  assign ovf_d = (opa_q[N-1] == bx[N-1]) && (SUM[N-1] != opa_q[N-1]);

  // NOTE: every always_comb output gets a value on every path (default first)
  // so no latch is inferred.
  always_comb begin
    disp_d = BinTC;
    unique case (state_q)
      LOAD_A, LOAD_B: disp_d = BinTC;
      EXEC:           disp_d = opb_q;
      SHOW:           disp_d = result_q;
      default:        disp_d = BinTC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= LOAD_A;
      opa_q     <= '0;
      opb_q     <= '0;
      add_sub_q <= OP_ADD;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      disp_q    <= '0;
    end else begin
      disp_q <= disp_d;
      if (ABORT) begin
        // Operands and result are kept so the user can still read them.
        state_q <= LOAD_A;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          LOAD_A: begin
            if (ent) begin
              if (ISVALID) begin
                opa_q   <= BinTC;
                err_q   <= 1'b0;
                state_q <= LOAD_B;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD_B: begin
            if (ent) begin
              if (ISVALID) begin
                opb_q     <= BinTC;
                add_sub_q <= OP;
                err_q     <= 1'b0;
                cnt_q     <= CW'(SETTLE_CYCLES - 1);
                state_q   <= EXEC;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          EXEC: begin
            // Adder inputs are frozen here; keypad entries are dropped.
            if (cnt_q == '0) begin
              result_q <= SUM;
              cout_q   <= COUT;
              ovf_q    <= ovf_d;
              done_q   <= 1'b1;
              state_q  <= SHOW;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          SHOW: begin
            if (ent) begin
              if (ISVALID) begin
                opa_q   <= BinTC;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                state_q <= LOAD_B;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  assign OPA     = opa_q;
  assign OPB     = opb_q;
  assign ADD_SUB = add_sub_q;
  assign RESULT  = result_q;
  assign COUT_Q  = cout_q;
  assign OVF     = ovf_q;
  assign ERR     = err_q;
  assign DONE    = done_q;
  assign STATE   = state_q;
  assign DISP    = disp_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random operations
// checked against a behavioural model of the calculator.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int N      = 8;
  localparam int SETTLE = 2;
  localparam int DEB    = 16;
`ifdef CALC_DEBOUNCE_EN
  localparam int EXTRA  = DEB;
`else
  localparam int EXTRA  = 0;
`endif

  logic         CLK = 1'b0;
  logic         RESET, ENTER, ABORT, OP, ISVALID;
  logic [N-1:0] BinTC, SUM;
  logic         COUT;
  logic [N-1:0] OPA, OPB, RESULT, DISP;
  logic         ADD_SUB, COUT_Q, OVF, ERR, DONE;
  logic [1:0]   STATE;

  always #5 CLK = ~CLK;

  // Behavioural stand-in for the external ripple-carry adder/subtractor.
  assign {COUT, SUM} = {1'b0, OPA} + {1'b0, (OPB ^ {N{ADD_SUB}})} + {8'b0, ADD_SUB};

  calc_sequencer #(
    .N              (N),
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENTER  (ENTER),
    .ABORT  (ABORT),
    .OP     (OP),
    .ISVALID(ISVALID),
    .BinTC  (BinTC),
    .SUM    (SUM),
    .COUT   (COUT),
    .OPA    (OPA),
    .OPB    (OPB),
    .ADD_SUB(ADD_SUB),
    .RESULT (RESULT),
    .COUT_Q (COUT_Q),
    .OVF    (OVF),
    .ERR    (ERR),
    .DONE   (DONE),
    .STATE  (STATE),
    .DISP   (DISP)
  );

  int n_checks = 0;
  int n_fail   = 0;

  state_e     m_state;
  logic [7:0] m_opa, m_opb, m_result;
  logic       m_add_sub, m_cout, m_ovf, m_err, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int ua, ub;
    ua = int'(a);
    ub = sub ? 256 - int'(b) : int'(b);
    return 9'(ua + ub);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    return (r > 127) || (r < -128);
  endfunction

  task automatic model_reset();
    m_state = LOAD_A; m_opa = '0; m_opb = '0; m_result = '0;
    m_add_sub = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_ent(input logic valid, input logic [7:0] val, input logic op);
    case (m_state)
      LOAD_A: if (valid) begin m_opa = val; m_err = 1'b0; m_state = LOAD_B; end
              else m_err = 1'b1;
      LOAD_B: if (valid) begin m_opb = val; m_add_sub = op; m_err = 1'b0; m_state = EXEC; end
              else m_err = 1'b1;
      SHOW:   if (valid) begin m_opa = val; m_done = 1'b0; m_err = 1'b0; m_state = LOAD_B; end
              else m_err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_abort();
    m_state = LOAD_A; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_exec_done();
    {m_cout, m_result} = ref_sum(m_opa, m_opb, m_add_sub);
    m_ovf   = ref_ovf(m_opa, m_opb, m_add_sub);
    m_done  = 1'b1;
    m_state = SHOW;
  endtask

  task automatic check_all();
    check("state",   STATE,   m_state);
    check("opa",     OPA,     m_opa);
    check("opb",     OPB,     m_opb);
    check("add_sub", ADD_SUB, m_add_sub);
    check("result",  RESULT,  m_result);
    check("cout_q",  COUT_Q,  m_cout);
    check("ovf",     OVF,     m_ovf);
    check("err",     ERR,     m_err);
    check("done",    DONE,    m_done);
  endtask

  // Raises ENTER and returns right after the edge at which the FSM acts on it.
  task automatic press(input logic valid, input logic [7:0] val, input logic op, input logic with_abort);
    @(negedge CLK);
    ENTER = 1'b1; ISVALID = valid; BinTC = val; OP = op;
    repeat (2 + EXTRA) @(negedge CLK);
    if (with_abort) ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    if (with_abort) model_abort();
    else model_ent(valid, val, op);
  endtask

  task automatic release_key();
    ENTER = 1'b0;
    repeat (4 + EXTRA) @(negedge CLK);
  endtask

  task automatic exec_phase();
    check_all();
    for (int i = 1; i < SETTLE; i++) begin
      @(negedge CLK);
      check("exec_hold", STATE, EXEC);
      if (i == 1) check("disp_exec", DISP, m_opb);
    end
    @(negedge CLK);
    model_exec_done();
    check_all();
    @(negedge CLK);
    check("disp_show", DISP, m_result);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op);
    press(1'b1, a, op, 1'b0);
    check_all();
    release_key();
    press(1'b1, b, op, 1'b0);
    exec_phase();
    release_key();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    logic       op;

    RESET = 1'b1; ENTER = 1'b0; ABORT = 1'b0; OP = 1'b0; ISVALID = 1'b0; BinTC = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all();
    check("disp_rst", DISP, 8'h00);
    RESET = 1'b0;
    BinTC = 8'h5A;
    repeat (2) @(negedge CLK);
    check("disp_load_a", DISP, 8'h5A);

    // Rejected entry in LOAD_A, then a valid negative operand.
    press(1'b0, 8'h33, OP_ADD, 1'b0);
    check_all();
    check("err_load_a", ERR, 1'b1);
    check("state_stay_a", STATE, 2'b00);
    release_key();
    press(1'b1, 8'hF6, OP_ADD, 1'b0);
    check_all();
    check("opa_f6", OPA, 8'hF6);
    check("err_clear", ERR, 1'b0);
    check("state_b", STATE, 2'b01);
    release_key();
    check("disp_load_b", DISP, 8'hF6);

    // Rejected entry in LOAD_B, then F6 + 0A wraps to 00 with carry.
    press(1'b0, 8'h80, OP_ADD, 1'b0);
    check_all();
    release_key();
    press(1'b1, 8'h0A, OP_ADD, 1'b0);
    exec_phase();
    release_key();
    check("wrap_result", RESULT, 8'h00);
    check("wrap_cout", COUT_Q, 1'b1);

    // Rejected entry while showing a result.
    press(1'b0, 8'h01, OP_ADD, 1'b0);
    check_all();
    check("err_show", ERR, 1'b1);
    release_key();

    run_op(8'd25, 8'd17, OP_ADD);
    check("add_result", RESULT, 8'd42);
    check("add_ovf",    OVF,    1'b0);
    check("add_cout",   COUT_Q, 1'b0);
    check("add_done",   DONE,   1'b1);
    check("add_state",  STATE,  2'b11);
    check("add_disp",   DISP,   8'd42);

    run_op(8'd100, 8'd100, OP_ADD);
    check("povf_result", RESULT, 8'hC8);
    check("povf_ovf",    OVF,    1'b1);
    check("povf_cout",   COUT_Q, 1'b0);

    run_op(8'd5, 8'd9, OP_SUB);
    check("sub_neg_result", RESULT, 8'hFC);
    check("sub_neg_ovf",    OVF,    1'b0);
    check("sub_neg_cout",   COUT_Q, 1'b0);

    run_op(8'd9, 8'd5, OP_SUB);
    check("sub_pos_result", RESULT, 8'h04);
    check("sub_pos_cout",   COUT_Q, 1'b1);

    // ABORT in the second EXEC cycle beats the pending sample.
    press(1'b1, 8'd7, OP_ADD, 1'b0);
    release_key();
    press(1'b1, 8'd3, OP_ADD, 1'b0);
    check("abort_exec1", STATE, 2'b10);
    @(negedge CLK);
    check("abort_exec2", STATE, 2'b10);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    model_abort();
    check_all();
    check("abort_state",  STATE,  2'b00);
    check("abort_done",   DONE,   1'b0);
    check("abort_result", RESULT, 8'h04);
    release_key();

    // ABORT together with the entry pulse drops the entry.
    press(1'b1, 8'h55, OP_ADD, 1'b1);
    check_all();
    check("abort_ent_opa", OPA, 8'd7);
    release_key();

    // A long ENTER hold must capture exactly once.
    press(1'b1, 8'h3C, OP_ADD, 1'b0);
    check_all();
    BinTC = 8'h11;
    repeat (50) @(negedge CLK);
    check_all();
    check("hold_state", STATE, 2'b01);
    check("hold_opa", OPA, 8'h3C);
    release_key();

    // Synchronous reset during EXEC discards the pending sample.
    press(1'b1, 8'h22, OP_SUB, 1'b0);
    check("rst_exec_state", STATE, 2'b10);
    RESET = 1'b1; ENTER = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    check_all();
    check("rst_exec_disp", DISP, 8'h00);
    repeat (4 + EXTRA) @(negedge CLK);

    // Random operations, occasionally preceded by a rejected entry.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3) == 0) begin
        press(1'b0, 8'($urandom), 1'b0, 1'b0);
        check_all();
        release_key();
      end
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 1'($urandom);
      run_op(a, b, op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
